// File: rtl/seeg_axil_ctrl_regs.sv
// AXI4-Lite register file for the sEEG host control bus: configuration words,
// a read-only live status word at index 1 and rising-edge command pulses from word 0.
module seeg_axil_ctrl_regs #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CMD_W    = 9
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESET,
    input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
    input  logic [2:0]               S_AXI_AWPROT,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
    input  logic [2:0]               S_AXI_ARPROT,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    output logic [CMD_W-1:0]         cmd_pulse,
    input  logic [31:0]              status_in,
    output logic [NUM_REGS*32-1:0]   cfg_regs
);

    localparam int unsigned IDX_W      = $clog2(NUM_REGS);
    localparam int unsigned BYTE_LIMIT = NUM_REGS * 4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic [ADDR_W-1:0]         awaddr_q, awaddr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [3:0]                wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [CMD_W-1:0]          cmd_pulse_q, cmd_pulse_d;

    logic [IDX_W-1:0]          w_idx_c, r_idx_c;
    logic                      w_oor_c, r_oor_c;
    logic [31:0]               wr_word_c;
    logic                      unused_c;

    assign w_idx_c  = awaddr_q[IDX_W+1:2];
    assign r_idx_c  = S_AXI_ARADDR[IDX_W+1:2];
    assign w_oor_c  = 32'(awaddr_q) >= BYTE_LIMIT;
    assign r_oor_c  = 32'(S_AXI_ARADDR) >= BYTE_LIMIT;
    assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q[1:0], S_AXI_ARADDR[1:0]};

    // Byte-lane merge of held write data onto the current word
    always_comb begin
        wr_word_c = regs_q[w_idx_c];
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) wr_word_c[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    always_comb begin
        regs_d      = regs_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        cmd_pulse_d = '0;

        if (S_AXI_AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = S_AXI_WDATA;
            wstrb_d  = S_AXI_WSTRB;
        end

        // Commit cycle: both halves held and no response outstanding
        if (aw_held_q && w_held_q && !bvalid_q) begin
            bvalid_d = 1'b1;
            if (w_oor_c) begin
                bresp_d = RESP_SLVERR;
            end else begin
                bresp_d = RESP_OKAY;
                if (w_idx_c != IDX_W'(1)) regs_d[w_idx_c] = wr_word_c;
                if (w_idx_c == IDX_W'(0))
                    cmd_pulse_d = wr_word_c[CMD_W-1:0] & ~regs_q[0][CMD_W-1:0];
            end
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;

        // Reads see pre-update register contents
        if (S_AXI_ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            if (r_oor_c) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = (r_idx_c == IDX_W'(1)) ? status_in : regs_q[r_idx_c];
                rresp_d = RESP_OKAY;
            end
        end
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        arready_d = !rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            regs_q      <= '0;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            cmd_pulse_q <= '0;
        end else begin
            regs_q      <= regs_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            cmd_pulse_q <= cmd_pulse_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign cmd_pulse     = cmd_pulse_q;
    assign cfg_regs      = regs_q;

endmodule

// File: tb/tb_seeg_axil_ctrl_regs.sv
// Scoreboard bench for seeg_axil_ctrl_regs; ADDR_W widened to 8 so byte address 0x80 is out of range.
module tb_seeg_axil_ctrl_regs;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CMD_W    = 9;
    localparam logic [1:0]  OK  = 2'b00;
    localparam logic [1:0]  ERR = 2'b10;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [ADDR_W-1:0]      awaddr = '0;
    logic                   awvalid = 1'b0;
    logic                   awready;
    logic [31:0]            wdata = '0;
    logic [3:0]             wstrb = '0;
    logic                   wvalid = 1'b0;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready = 1'b1;
    logic [ADDR_W-1:0]      araddr = '0;
    logic                   arvalid = 1'b0;
    logic                   arready;
    logic [31:0]            rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready = 1'b1;
    logic [CMD_W-1:0]       cmd_pulse;
    logic [31:0]            status_in = '0;
    logic [NUM_REGS*32-1:0] cfg_regs;

    logic [1:0]       exp_b[$];
    logic [33:0]      exp_r[$];
    logic [CMD_W-1:0] exp_p[$];
    logic [1:0]       eb;
    logic [33:0]      er;
    logic [CMD_W-1:0] ep;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    seeg_axil_ctrl_regs #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .CMD_W(CMD_W)) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),   .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),   .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready),
        .cmd_pulse(cmd_pulse),  .status_in(status_in), .cfg_regs(cfg_regs)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT presents one
    always @(negedge clk) begin
        if (bvalid && bready) begin
            if (exp_b.size() == 0) chk("b_unexpected", 32'(bvalid), 32'd0);
            else begin
                eb = exp_b.pop_front();
                chk("bresp", 32'(bresp), 32'(eb));
            end
        end
        if (rvalid && rready) begin
            if (exp_r.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
            else begin
                er = exp_r.pop_front();
                chk("rdata", rdata, er[31:0]);
                chk("rresp", 32'(rresp), 32'(er[33:32]));
            end
        end
        if (cmd_pulse != '0) begin
            if (exp_p.size() == 0) chk("pulse_unexpected", 32'(cmd_pulse), 32'd0);
            else begin
                ep = exp_p.pop_front();
                chk("cmd_pulse", 32'(cmd_pulse), 32'(ep));
            end
        end
    end

    task automatic exit_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_first_edge", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'({awready, wready, arready}), 32'h7);
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r, input int aw_dly = 0, input int w_dly = 0,
                      input int b_hold = 0);
        int  n;
        bit  aw_done;
        bit  w_done;
        n = 0; aw_done = 1'b0; w_done = 1'b0;
        exp_b.push_back(r);
        bready = (b_hold == 0);
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && n < 100) begin
            awvalid = !aw_done && (n >= aw_dly);
            wvalid  = !w_done && (n >= w_dly);
            @(negedge clk);
            if (awvalid && awready) aw_done = 1'b1;
            if (wvalid && wready)   w_done  = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk("wr_handshake_timeout", 32'({aw_done, w_done}), 32'h3);
        @(negedge clk);
        chk("bvalid_not_early", 32'(bvalid), 32'd0);
        @(negedge clk);
        chk("bvalid_latency", 32'(bvalid), 32'd1);
        if (b_hold > 0) begin
            for (int i = 0; i < b_hold; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk("b_stall", 32'({awready, wready, bvalid}), 32'h1);
            end
            @(posedge clk); #1;
            bready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_b", 32'({awready, wready}), 32'h3);
        @(posedge clk); #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        int n;
        bit done;
        n = 0; done = 1'b0;
        exp_r.push_back({r, d});
        araddr = a; arvalid = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            if (arready) done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!done) chk("ar_timeout", 32'(arready), 32'd1);
        n = 0; done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (rvalid) done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("r_timeout", 32'(rvalid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'({awready, wready, arready}), 32'd0);
        chk("reset_valid", 32'({bvalid, rvalid}), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_resp", 32'({bresp, rresp}), 32'd0);
        chk("reset_pulse", 32'(cmd_pulse), 32'd0);
        chk("reset_cfg", 32'(|cfg_regs), 32'd0);
        exit_reset();

        // Configuration words and read-back
        wr(8'h0C, 32'h0001_0001, 4'hF, OK);
        wr(8'h10, 32'h0005_0001, 4'hF, OK);
        wr(8'h4C, 32'h0000_0004, 4'hF, OK);
        wr(8'h50, 32'h0000_0001, 4'hF, OK);
        rd(8'h0C, 32'h0001_0001, OK);
        rd(8'h10, 32'h0005_0001, OK);
        rd(8'h4C, 32'h0000_0004, OK);
        rd(8'h50, 32'h0000_0001, OK);
        chk("cfg_word19", cfg_regs[19*32 +: 32], 32'd4);
        chk("cfg_word20", cfg_regs[20*32 +: 32], 32'd1);
        chk("cfg_word3", cfg_regs[3*32 +: 32], 32'h0001_0001);

        // Command pulses: rising bits only, strobe-masked lanes cannot pulse
        exp_p.push_back(9'h004);
        wr(8'h00, 32'h0000_0004, 4'hF, OK);
        wr(8'h00, 32'h0000_0004, 4'hF, OK);
        wr(8'h00, 32'h0000_0000, 4'hF, OK);
        exp_p.push_back(9'h1C0);
        wr(8'h00, 32'h0000_01C0, 4'hF, OK);
        wr(8'h00, 32'h0000_0000, 4'hF, OK);
        exp_p.push_back(9'h100);
        wr(8'h00, 32'h0000_01FF, 4'b0010, OK);
        rd(8'h00, 32'h0000_0100, OK);

        // Skewed AW/W with a stalled B channel
        wr(8'h14, 32'hCAFE_0001, 4'hF, OK, 0, 5, 10);
        wr(8'h18, 32'hBEEF_0002, 4'hF, OK, 5, 0, 10);
        rd(8'h14, 32'hCAFE_0001, OK);
        rd(8'h18, 32'hBEEF_0002, OK);

        // Partial strobes
        wr(8'h0C, 32'hFFFF_FFFF, 4'hF, OK);
        wr(8'h0C, 32'h1234_5678, 4'b0101, OK);
        rd(8'h0C, 32'hFF34_FF78, OK);

        // Out of range and read-only status word
        wr(8'h80, 32'hDEAD_BEEF, 4'hF, ERR);
        rd(8'h80, 32'h0000_0000, ERR);
        rd(8'h00, 32'h0000_0100, OK);
        status_in = 32'h0000_005A;
        wr(8'h04, 32'h0000_AAAA, 4'hF, OK);
        rd(8'h04, 32'h0000_005A, OK);
        chk("cfg_word1_ro", cfg_regs[1*32 +: 32], 32'd0);

        // Reset while only AW of a word-0 write is held
        awaddr = 8'h00; awvalid = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (awready) n = 1000;
            @(posedge clk); #1;
            n++;
        end
        awvalid = 1'b0;
        if (n < 1000) chk("rst_aw_timeout", 32'(awready), 32'd1);
        wdata = 32'h0000_001F; wstrb = 4'hF;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_bvalid", 32'(bvalid), 32'd0);
        exit_reset();
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_bvalid", 32'({bvalid, cmd_pulse}), 32'd0);
        end
        @(posedge clk); #1;
        rd(8'h00, 32'h0000_0000, OK);

        repeat (4) @(posedge clk);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
        chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
        chk("pulse_queue_drained", 32'(exp_p.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seeg_axil_ctrl_regs.md
Name: seeg_axil_ctrl_regs

Overview:
AXI4-Lite slave register file that terminates the host control bus of the sEEG top. It holds stimulation/record configuration words and the batch-size and loopback settings. The command register at word 0 is decoded into one-cycle command pulses for the record, impedance-check and stimulation controllers. A read-only status word is exposed for host polling.

Parameters:
ADDR_W, 7, byte-address width (word index = addr[ADDR_W-1:2])
NUM_REGS, 32, implemented 32-bit words; byte addresses >= NUM_REGS*4 are out of range
CMD_W, 9, number of decoded command bits in word 0

Ports:
S_AXI_ACLK  in  1  sole clock
S_AXI_ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
cmd_pulse  out  CMD_W  one-cycle command strobes: bit0 start_record, bit1 stop_record, bit2 start_zcheck, bit6 start_stim_finite, bit7 start_stim_infinite, bit8 stop_stim_infinite; other bits are generic
status_in  in  32  live status, read-only at word 1
cfg_regs  out  NUM_REGS*32  flat register image, word k at [32k+31:32k]

Behaviour:
- Clock and reset: one clock, S_AXI_ACLK; S_AXI_ARESET is synchronous and active-high.
- Reset: all registers 0; READY, BVALID, RVALID 0; cmd_pulse 0; RDATA 0; RESP 00. AWREADY, WREADY and ARREADY rise the first cycle after reset deasserts.
- Write channel:
  - AW and W are captured independently, in any order or the same cycle.
  - AWREADY is high when no address is held and BVALID=0. WREADY is high when no data is held and BVALID=0. Each drops the cycle after its handshake.
  - The cycle after both are held: byte lanes with WSTRB=1 update the register, BVALID=1, and BRESP is set.
  - BVALID holds until BREADY. The held AW/W are released on the B handshake; READYs reassert the next cycle.
  - Only one write is in flight at a time.
- Write decode:
  - Word 1 is read-only. A write to it is discarded with OKAY.
  - An address >= NUM_REGS*4 is discarded with SLVERR.
  - addr[1:0] are ignored.
- Command decode:
  - On the update cycle of a write to word 0, cmd_pulse[i] = 1 for exactly one cycle for every bit i < CMD_W that goes 0->1 in the updated value.
  - Rewriting a 1 produces no pulse. Writing 0 clears the word, which arms the next pulse.
  - Strobe-masked lanes keep their old bits and cannot pulse.
- Read channel:
  - ARREADY is high when RVALID=0.
  - On the AR handshake, RDATA and RRESP are registered and RVALID=1 the next cycle. They hold until RREADY; ARREADY reasserts the cycle after the R handshake.
  - Word 1 returns status_in as sampled on the AR handshake cycle.
  - Out-of-range reads return RDATA=0 with RRESP=SLVERR.
- Read/write interaction:
  - Read and write paths are independent and may complete in the same cycle.
  - A read of a word updated in the same cycle returns the pre-update value.
- cfg_regs: registered, reflects an update the cycle after the update cycle.
- Reset mid-transaction: in-flight AW/W/AR are dropped, no response is issued, and no cmd_pulse is generated.

Test Plan:
1. Write 0x0001_0001 to 0x0C, 0x0005_0001 to 0x10, 0x0004 to 0x4C, 0x0001 to 0x50 -> each BRESP=00; read-back returns the same values; cfg_regs word 19 = 4 and word 20 = 1.
2. Write 0x4 to word 0 -> cmd_pulse=0x004 for exactly 1 cycle. Write 0x4 again -> no pulse. Write 0 then 0x1C0 -> a single 0x1C0 pulse.
3. AW presented 5 cycles before W, then W before AW -> both complete. BVALID rises 1 cycle after the later handshake and is held 10 cycles with BREADY=0 -> no new AWREADY until the B handshake.
4. Word 3 = 0xFFFF_FFFF, then write 0x1234_5678 with WSTRB=0101 -> reads 0xFF34_FF78.
5. Write to 0x80 -> SLVERR with no state change. Read 0x80 -> RDATA=0, RRESP=10. Write 0xAAAA to word 1 with status_in=0x5A -> OKAY; the read returns 0x5A.
6. Assert reset while a write to word 0 holds only AW -> no BVALID and no pulse; after reset, word 0 reads 0 and the READYs return the next cycle.
